binary_counter: RTL and testbench



---
 rtl/binary_counter.sv | 45 ++++
 tb/tb_binary_counter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/binary_counter.sv
// Gated binary up-counter with async clear and terminal-count decode; COUNTER_SATURATE_EN selects saturate instead of wrap.
// Latency: cnt updates one clk edge after en is sampled high; tc is combinational from cnt in the same cycle.
// Backpressure: none; en is a plain count enable with no handshake, and clr overrides it at any time.
module binary_counter #(
    parameter int CNTR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  en,
    output logic [CNTR_WIDTH-1:0] cnt,
    output logic                  tc
);

    localparam logic [CNTR_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

    logic [CNTR_WIDTH-1:0] cnt_d;
    logic [CNTR_WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
`ifdef COUNTER_SATURATE_EN
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
`else
            // Natural modulo-2^W wrap from the adder carry-out being dropped.
            cnt_d = cnt_q + CNT_ONE;
`endif
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_binary_counter.sv
// Bench for binary_counter at widths 3 and 1 against an arithmetic reference model.
module tb_binary_counter;

    logic       clk;
    logic       clr;
    logic       en;
    logic [2:0] cnt3;
    logic       tc3;
    logic [0:0] cnt1;
    logic       tc1;

    int n_checks = 0;
    int n_pass   = 0;
    int exp3     = 0;
    int exp1     = 0;

    binary_counter #(.CNTR_WIDTH(3)) dut (
        .clk (clk),
        .clr (clr),
        .en  (en),
        .cnt (cnt3),
        .tc  (tc3)
    );

    binary_counter #(.CNTR_WIDTH(1)) dut_w1 (
        .clk (clk),
        .clr (clr),
        .en  (en),
        .cnt (cnt1),
        .tc  (tc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int next_val(input int v, input int w);
        int top;
        top = (1 << w) - 1;
`ifdef COUNTER_SATURATE_EN
        return (v == top) ? v : v + 1;
`else
        return (v + 1) % (1 << w);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_cnt3"}, {29'd0, cnt3}, exp3);
        chk({tag, "_tc3"},  {31'd0, tc3},  (exp3 == 7) ? 1 : 0);
        chk({tag, "_cnt1"}, {31'd0, cnt1}, exp1);
        chk({tag, "_tc1"},  {31'd0, tc1},  (exp1 == 1) ? 1 : 0);
    endtask

    // Drive on the falling edge, advance the model at the rising edge, sample 1 ns later.
    task automatic cycle(input logic e, input logic c, input string tag);
        @(negedge clk);
        en  = e;
        clr = c;
        if (c) begin
            exp3 = 0;
            exp1 = 0;
        end
        @(posedge clk);
        if (!clr && en) begin
            exp3 = next_val(exp3, 3);
            exp1 = next_val(exp1, 1);
        end
        #1;
        chk_all(tag);
    endtask

    initial begin
        clr = 1'b1;
        en  = 1'b0;
        #1;
        chk_all("reset_t0");

        for (int i = 0; i < 3; i++) cycle(1'($urandom_range(0, 1)), 1'b1, "reset_hold");

        // Free count over two full periods.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, "free");

        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, "to4");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "hold");
        cycle(1'b1, 1'b0, "resume");

        cycle(1'b1, 1'b0, "to6");
        @(negedge clk);
        en = 1'b0;
        #2;
        clr = 1'b1;
        exp3 = 0;
        exp1 = 0;
        #1;
        chk_all("async_clr");
        #1;
        clr = 1'b0;
        #1;
        chk_all("async_rel");
        cycle(1'b1, 1'b0, "after_clr");

        // Long enabled run: wraps by default, pins at all-ones when saturating.
        cycle(1'b0, 1'b1, "pre_run_clr");
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, "run12");
        cycle(1'b0, 1'b1, "post_run_clr");

        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
